// File: rtl/seq_shift_add_multiplier_if.sv
// Handshake and data bundle for the sequential shift-and-add multiplier.
// The master side requests a product, and the slave side (the multiplier) returns it.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 3
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product_out;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product_out
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product_out
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier: a single adder is iterated over WIDTH cycles.
// Signed operands are multiplied as magnitudes, and the sign is applied when the result is written out.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    seq_shift_add_multiplier_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [WIDTH-1:0]       ma;
    logic [WIDTH-1:0]       mb;
    logic [2*WIDTH-1:0]     acc;
    logic [CW-1:0]          cnt;
    logic                   neg;
    logic                   done_r;
    logic [2*WIDTH-1:0]     product_r;

    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [2*WIDTH-1:0]     addend;
    logic                   last_step;

    // The magnitude is WIDTH-bit unsigned, so the most negative input maps onto the top code.
    assign a_mag     = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_mag     = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    assign addend    = {{WIDTH{1'b0}}, ma} << cnt;
    assign last_step = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The sign is dropped for zero operands so that the result is never written as a negated zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            ma        <= '0;
            mb        <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ma  <= a_mag;
                        mb  <= b_mag;
                        neg <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])
                               & (|bus.a) & (|bus.b);
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    if (mb[0]) begin
                        acc <= acc + addend;
                    end
                    mb  <= mb >> 1;
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    product_r <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
                    done_r    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_r;
    assign bus.product_out = product_r;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed-vector bench for the shift-and-add multiplier. The main instance uses WIDTH=3,
// and a second instance uses WIDTH=8 with random operands checked against a behavioural product.
module tb_seq_shift_add_multiplier;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    seq_shift_add_multiplier_if #(.WIDTH(3)) bus3 ();
    seq_shift_add_multiplier_if #(.WIDTH(8)) bus8 ();

    seq_shift_add_multiplier #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sm;
        logic [2:0] a;
        logic [2:0] b;
        logic [5:0] exp;
    } vec_t;

    vec_t table3 [14];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts one operation on the WIDTH=3 instance, waits for done, and checks that the pulse lasts one cycle and the result holds.
    task automatic apply_stimulus(input logic sm, input logic [2:0] a, input logic [2:0] b,
                                  output logic [5:0] prod, output int lat);
        @(posedge clk); #1;
        bus3.signed_mode = sm; bus3.a = a; bus3.b = b; bus3.start = 1'b1;
        @(posedge clk); #1;
        bus3.start = 1'b0;
        bus3.a = ~a; bus3.b = ~b; bus3.signed_mode = ~sm;
        lat = 0;
        while (!bus3.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = bus3.product_out;
        @(posedge clk); #1;
        check_output("done_pulse_width", {31'b0, bus3.done}, 32'd0);
        check_output("product_hold", {26'b0, bus3.product_out}, {26'b0, prod});
    endtask

    task automatic apply_stimulus8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                                   output logic [15:0] prod, output int lat);
        @(posedge clk); #1;
        bus8.signed_mode = sm; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a = 8'h5A;
        lat = 0;
        while (!bus8.done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = bus8.product_out;
    endtask

    initial begin
        logic [5:0]  prod;
        logic [15:0] prod8;
        logic [5:0]  exp6;
        logic [15:0] exp16;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rs;
        int          lat;
        int          n;
        int          seen;

        vectors = 0;
        miscompares = 0;
        table3[0]  = '{1'b0, 3'd7,    3'd7,    6'b110001};
        table3[1]  = '{1'b1, 3'b100,  3'b011,  6'b110100};
        table3[2]  = '{1'b1, 3'b100,  3'b100,  6'b010000};
        table3[3]  = '{1'b1, 3'b000,  3'b101,  6'b000000};
        table3[4]  = '{1'b0, 3'b101,  3'b110,  6'b011110};
        table3[5]  = '{1'b1, 3'b101,  3'b110,  6'b000110};
        table3[6]  = '{1'b1, 3'b011,  3'b011,  6'b001001};
        table3[7]  = '{1'b1, 3'b111,  3'b001,  6'b111111};
        table3[8]  = '{1'b0, 3'd0,    3'd7,    6'b000000};
        table3[9]  = '{1'b0, 3'd1,    3'd4,    6'b000100};
        table3[10] = '{1'b1, 3'b011,  3'b100,  6'b110100};
        table3[11] = '{1'b1, 3'b111,  3'b111,  6'b000001};
        table3[12] = '{1'b1, 3'b010,  3'b101,  6'b111010};
        table3[13] = '{1'b0, 3'd7,    3'd1,    6'b000111};

        rst = 1'b1;
        bus3.start = 1'b0; bus3.signed_mode = 1'b0; bus3.a = '0; bus3.b = '0;
        bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = '0; bus8.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", {31'b0, bus3.busy}, 32'd0);
        check_output("reset_done", {31'b0, bus3.done}, 32'd0);
        check_output("reset_product", {26'b0, bus3.product_out}, 32'd0);
        rst = 1'b0;

        $display("[TB] directed table, WIDTH=3");
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(table3[i].sm, table3[i].a, table3[i].b, prod, lat);
            check_output($sformatf("vec%0d_latency", i), lat, 32'd4);
            check_output($sformatf("vec%0d_product", i), {26'b0, prod}, {26'b0, table3[i].exp});
        end

        $display("[TB] reset during RUN");
        @(posedge clk); #1;
        bus3.signed_mode = 1'b0; bus3.a = 3'd3; bus3.b = 3'd3; bus3.start = 1'b1;
        @(posedge clk); #1;
        bus3.start = 1'b0;
        @(posedge clk); #1;
        check_output("midrun_busy_before", {31'b0, bus3.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_output("midrun_busy", {31'b0, bus3.busy}, 32'd0);
        check_output("midrun_done", {31'b0, bus3.done}, 32'd0);
        check_output("midrun_product", {26'b0, bus3.product_out}, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus3.done) seen++;
        end
        check_output("midrun_no_done", seen, 32'd0);
        apply_stimulus(1'b0, 3'd3, 3'd3, prod, lat);
        check_output("after_reset_latency", lat, 32'd4);
        check_output("after_reset_product", {26'b0, prod}, 32'd9);

        $display("[TB] reset and start together");
        @(posedge clk); #1;
        rst = 1'b1; bus3.start = 1'b1; bus3.a = 3'd5; bus3.b = 3'd5;
        @(posedge clk); #1;
        rst = 1'b0; bus3.start = 1'b0;
        check_output("rst_start_busy", {31'b0, bus3.busy}, 32'd0);

        $display("[TB] start held high across operations");
        @(posedge clk); #1;
        bus3.signed_mode = 1'b0; bus3.a = 3'd7; bus3.b = 3'd7; bus3.start = 1'b1;
        @(posedge clk); #1;
        bus3.a = 3'd2; bus3.b = 3'd3;
        n = 0;
        while (!bus3.done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("hold_first_latency", n, 32'd4);
        check_output("hold_first_product", {26'b0, bus3.product_out}, 32'd49);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n < 5) begin
                check_output("hold_product_stable", {26'b0, bus3.product_out}, 32'd49);
            end
        end while (!bus3.done && n < 20);
        bus3.start = 1'b0;
        check_output("hold_done_spacing", n, 32'd5);
        check_output("hold_second_product", {26'b0, bus3.product_out}, 32'd6);
        @(posedge clk); #1;
        check_output("hold_idle_after_release", {31'b0, bus3.busy}, 32'd0);

        $display("[TB] exhaustive WIDTH=3");
        for (int s = 0; s < 2; s++) begin
            for (int ia = 0; ia < 8; ia++) begin
                for (int ib = 0; ib < 8; ib++) begin
                    int sa;
                    int sb;
                    sa = (s == 1 && ia >= 4) ? ia - 8 : ia;
                    sb = (s == 1 && ib >= 4) ? ib - 8 : ib;
                    exp6 = 6'(sa * sb);
                    apply_stimulus(s[0], 3'(ia), 3'(ib), prod, lat);
                    check_output($sformatf("ex_s%0d_a%0d_b%0d", s, ia, ib), {26'b0, prod}, {26'b0, exp6});
                end
            end
        end

        $display("[TB] random WIDTH=8");
        for (int i = 0; i < 150; i++) begin
            int sa;
            int sb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i == 0) begin ra = 8'h80; rb = 8'h80; end
            if (i == 1) begin ra = 8'hFF; rb = 8'hFF; end
            rs = (i % 2 == 1);
            sa = rs ? int'($signed(ra)) : int'(ra);
            sb = rs ? int'($signed(rb)) : int'(rb);
            exp16 = 16'(sa * sb);
            apply_stimulus8(rs, ra, rb, prod8, lat);
            check_output($sformatf("w8_%0d_latency", i), lat, 32'd9);
            check_output($sformatf("w8_%0d_s%0d_%0h_%0h", i, rs, ra, rb), {16'b0, prod8}, {16'b0, exp16});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
